// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: default operand width and operation encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 24;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_MUL   = 3'd2,
    ALU_SHR   = 3'd3,
    ALU_INC   = 3'd4,
    ALU_PASSB = 3'd5,
    ALU_PASSA = 3'd6,
    ALU_ZERO  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result from op, A and B, truncated to WIDTH bits.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  alu_op_e            i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      // Context width is WIDTH, so only the low product bits are ever formed.
      ALU_MUL:   o_result = i_a * i_b;
      ALU_SHR:   o_result = {1'b0, i_a[WIDTH-1:1]};
      ALU_INC:   o_result = i_a + WIDTH'(1);
      ALU_PASSB: o_result = i_b;
      ALU_PASSA: o_result = i_a;
      ALU_ZERO:  o_result = '0;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one result and zero flag per cycle, 1-cycle latency, synchronous reset.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       control_signal,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] C_out,
  output logic             Z
);

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_c;
  logic             r_z;

  assign w_op = alu_op_e'(control_signal);

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op     (w_op),
    .i_a      (A_in),
    .i_b      (B_in),
    .o_result (w_result)
  );

  // Flag is derived from the same next-state value so it always matches C_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= '0;
      r_z <= 1'b1;
    end else begin
      r_c <= w_result;
      r_z <= (w_result == '0);
    end
  end

  assign C_out = r_c;
  assign Z     = r_z;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps followed by randomized ops vs a model.
module tb_alu;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   control_signal = 3'd0;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic [W-1:0] C_out;
  logic         Z;

  int n_cmp = 0;
  int n_bad = 0;

  alu #(
    .WIDTH (W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .A_in           (A_in),
    .B_in           (B_in),
    .C_out          (C_out),
    .Z              (Z)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: plain unsigned integer math reduced modulo 2^W.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned m;
    longint unsigned x;
    longint unsigned y;
    longint unsigned r;
    m = 64'd1 << W;
    x = 64'(a);
    y = 64'(b);
    case (op)
      3'd0:    r = (x + y) % m;
      3'd1:    r = (x + m - y) % m;
      3'd2:    r = (x * y) % m;
      3'd3:    r = x / 2;
      3'd4:    r = (x + 1) % m;
      3'd5:    r = y;
      3'd6:    r = x;
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  // Apply inputs away from the edge, then sample just after the capturing edge.
  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic r);
    @(negedge clk);
    control_signal = op;
    A_in           = a;
    B_in           = b;
    rst            = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp_c, input logic exp_z);
    n_cmp++;
    assert (C_out === exp_c) else begin
      n_bad++;
      $error("FAIL %s C_out: observed %h expected %h", tag, C_out, exp_c);
    end
    n_cmp++;
    assert (Z === exp_z) else begin
      n_bad++;
      $error("FAIL %s Z: observed %b expected %b", tag, Z, exp_z);
    end
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         r;
    logic [W-1:0] exp_c;

    // Reset with arbitrary inputs, then release.
    drive(3'd2, 24'h5A5A5A, 24'h3C3C3C, 1'b1);
    check("reset", 24'h000000, 1'b1);
    drive(3'd0, 24'd1, 24'd2, 1'b0);
    check("post_reset_add", 24'd3, 1'b0);

    // Back-to-back ops.
    drive(3'd1, 24'd1, 24'd2, 1'b0);
    check("sub_wrap", 24'hFFFFFF, 1'b0);
    drive(3'd2, 24'd1, 24'd2, 1'b0);
    check("mul", 24'd2, 1'b0);
    drive(3'd3, 24'd1024, $urandom, 1'b0);
    check("shr", 24'd512, 1'b0);
    drive(3'd4, 24'd1, $urandom, 1'b0);
    check("inc", 24'd2, 1'b0);
    drive(3'd0, 24'd0, 24'd2, 1'b0);
    check("add_zero_a", 24'd2, 1'b0);

    // Wrap and zero flag.
    drive(3'd0, 24'hFFFFFF, 24'd1, 1'b0);
    check("add_wrap", 24'd0, 1'b1);
    drive(3'd4, 24'hFFFFFF, $urandom, 1'b0);
    check("inc_wrap", 24'd0, 1'b1);
    drive(3'd1, 24'd5, 24'd5, 1'b0);
    check("sub_equal", 24'd0, 1'b1);

    // MUL truncation.
    drive(3'd2, 24'h001000, 24'h001000, 1'b0);
    check("mul_trunc_zero", 24'h000000, 1'b1);
    drive(3'd2, 24'h000FFF, 24'h000FFF, 1'b0);
    check("mul_trunc", 24'hFFE001, 1'b0);

    // SHR fills MSB with zero.
    drive(3'd3, 24'hFFFFFF, $urandom, 1'b0);
    check("shr_msb", 24'h7FFFFF, 1'b0);

    // Pass and zero ops with the unused operand randomized.
    drive(3'd5, $urandom, 24'hABCDEF, 1'b0);
    check("passb", 24'hABCDEF, 1'b0);
    drive(3'd6, 24'h123456, $urandom, 1'b0);
    check("passa", 24'h123456, 1'b0);
    drive(3'd7, $urandom, $urandom, 1'b0);
    check("zero_op", 24'd0, 1'b1);

    // Result holds until the next edge.
    drive(3'd5, 24'd0, 24'h00BEEF, 1'b0);
    @(negedge clk);
    check("hold", 24'h00BEEF, 1'b0);

    // Reset mid-stream discards the in-flight op, then results resume.
    drive(3'd0, 24'd1, 24'd2, 1'b1);
    check("mid_reset", 24'd0, 1'b1);
    drive(3'd0, 24'd1, 24'd2, 1'b0);
    check("resume_add", 24'd3, 1'b0);
    drive(3'd2, 24'd7, 24'd6, 1'b0);
    check("resume_mul", 24'd42, 1'b0);

    // Randomized ops against the reference model, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 3)) : 24'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 24'($urandom);
      if ($urandom_range(0, 7) == 0) b = 24'hFFFFFF - a + 24'd1;
      r  = ($urandom_range(0, 15) == 0);
      drive(op, a, b, r);
      exp_c = r ? 24'd0 : model(op, a, b);
      check($sformatf("rand%0d_op%0d", i, op), exp_c, exp_c == 24'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 24-bit integer ALU for the matrix-multiplication processor datapath.
- Takes two operands and a 3-bit operation select; produces a registered result and a zero flag.
- Sits between the register file/accumulator and the writeback path; the control unit drives the operation select.

Parameters:
- WIDTH, 24, operand/result width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- control_signal  input  3  operation select (encoding below)
- A_in  input  WIDTH  operand A (unsigned)
- B_in  input  WIDTH  operand B (unsigned)
- C_out  output  WIDTH  registered result
- Z  output  1  registered zero flag; 1 when C_out == 0

Behaviour:
- One clock; reset is synchronous and active-high. rst sampled on the rising clk edge: C_out <= 0, Z <= 1. rst has priority over any operation.
- Latency is 1 cycle. Inputs sampled at rising edge N; C_out and Z are valid after edge N and hold until edge N+1.
- No handshake. A new operation is accepted every cycle, so throughput is one result per cycle.
- Operation encoding, unsigned, results truncated to WIDTH bits:
  - 0 ADD: A + B; carry discarded (0xFFFFFF + 1 = 0).
  - 1 SUB: A - B; two's-complement wrap (1 - 2 = 0xFFFFFF).
  - 2 MUL: low WIDTH bits of A * B.
  - 3 SHR: A >> 1, logical; MSB filled with 0.
  - 4 INC: A + 1; wraps 0xFFFFFF -> 0.
  - 5 PASSB: B.
  - 6 PASSA: A.
  - 7 ZERO: 0.
- B_in is ignored for ops 3, 4, 6 and 7; A_in is ignored for ops 5 and 7.
- Z is computed from the same next-state result and registered together with C_out. Z == 1 exactly when the registered C_out is all zeros, for every operation.
- X/undriven inputs are not required to produce defined outputs. Once all inputs are known for one clock, the outputs are defined.
- Reset asserted mid-stream discards the in-flight result. The first post-reset result is produced one cycle after the first non-reset edge.

Decomposition:
- Shared package alu_pkg:
  - WIDTH default constant.
  - 3-bit op enumeration: ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_SHR=3, ALU_INC=4, ALU_PASSB=5, ALU_PASSA=6, ALU_ZERO=7.
- One combinational sub-module, alu_core: computes the next result from op, A and B.
- The top alu holds the output registers, reset, and the zero detect.

Test Plan:
- Reset: assert rst for 1 cycle with arbitrary inputs -> C_out=0, Z=1. Deassert with op=0, A=1, B=2 -> next edge C_out=3, Z=0.
- Back-to-back ops on consecutive edges, each checked one cycle after issue:
  - A=1, B=2: op0 -> 3; op1 -> 0xFFFFFF; op2 -> 2.
  - A=1024, op3 -> 512.
  - A=1, op4 -> 2.
  - A=0, B=2, op0 -> 2. Z=0 throughout.
- Wrap and zero flag:
  - op0 A=0xFFFFFF, B=1 -> C_out=0, Z=1.
  - op4 A=0xFFFFFF -> 0, Z=1.
  - op1 A=5, B=5 -> 0, Z=1.
- MUL truncation: A=0x001000, B=0x001000 -> 0x000000, Z=1. A=0x000FFF, B=0x000FFF -> 0xFFE001.
- Pass and zero ops: op5 B=0xABCDEF -> 0xABCDEF; op6 A=0x123456 -> 0x123456; op7 -> 0, Z=1. Unused operands are toggled randomly with no effect.
- Reset mid-stream: issue op0 A=1, B=2 and assert rst on the same edge -> C_out=0, Z=1 (no 3 appears). Then resume -> results resume with 1-cycle latency.
